// File: rtl/ls164_load_ctrl.sv
// rtl/ls164_load_ctrl.sv - byte serialiser and clock/clear generator for a downstream 74LS164
//
// Purpose:
//   Accepts a byte on LOAD and shifts it out on SER with a generated shift
//   clock SCK, then pulses DONE. CLR_REQ issues a clear on SR_MR_n instead.
//   Every output is a flop, so nothing combinational reaches the 74LS164 pins.
//
// Parameters:
//   DIV        CP cycles per half-period of SCK (1..255)
//   MSB_FIRST  1: DATA[7] shifted first (ends in Q7); 0: DATA[0] shifted first
//
// Ports:
//   CP       in   system clock, rising edge
//   MR       in   asynchronous active-high reset
//   DATA     in   [7:0] byte to serialise, sampled when LOAD is accepted
//   LOAD     in   load request, accepted when LOAD & READY at a CP edge
//   CLR_REQ  in   downstream clear request, wins over LOAD
//   READY    out  idle, LOAD or CLR_REQ will be accepted
//   SER      out  serial data to DSA/DSB
//   SCK      out  shift clock to the 74LS164 CP
//   SR_MR_n  out  active-low clear to the 74LS164 MR_n
//   DONE     out  one-cycle pulse after the 8th shift

module ls164_load_ctrl #(
  parameter int unsigned DIV       = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       CP,
  input  logic       MR,
  input  logic [7:0] DATA,
  input  logic       LOAD,
  input  logic       CLR_REQ,
  output logic       READY,
  output logic       SER,
  output logic       SCK,
  output logic       SR_MR_n,
  output logic       DONE
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       ser_q, ser_d;
  // Reset leaves the divider at zero; the first CLEAR cycle after reset
  // loads it so the downstream clear still lasts a full DIV cycles.
  logic       armed_q, armed_d;
  logic       sck_q, ready_q, done_q, mr_n_q;
  logic       bit_last;

  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
    if (MSB_FIRST) begin
      return b[3'd7 - idx];
    end
    return b[idx];
  endfunction

  // Terminal detect: the 8th bit is in flight, so no further increment.
  assign bit_last = (bit_q == 3'd7);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ser_d   = ser_q;
    armed_d = armed_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (!armed_q) begin
          div_d   = DIV_M1;
          armed_d = 1'b1;
        end else if (div_q == 8'd0) begin
          state_d = ST_IDLE;
          div_d   = DIV_M1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          div_d   = DIV_M1;
        end else if (LOAD) begin
          state_d = ST_SETUP;
          div_d   = DIV_M1;
          byte_d  = DATA;
          bit_d   = 3'd0;
          // First bit comes straight from DATA so SER is valid at acceptance.
          ser_d   = pick_bit(DATA, 3'd0);
        end
      end
      ST_SETUP: begin
        if (div_q == 8'd0) begin
          state_d = ST_HIGH;
          div_d   = DIV_M1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (div_q == 8'd0) begin
          div_d = DIV_M1;
          if (bit_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
            bit_d   = bit_q + 3'd1;
            // Next bit changes on the same edge SCK falls, giving a full
            // low phase of setup before the next rise.
            ser_d   = pick_bit(byte_q, bit_q + 3'd1);
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        div_d   = DIV_M1;
      end
      default: begin
        state_d = ST_CLEAR;
        div_d   = DIV_M1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q <= ST_CLEAR;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      ser_q   <= 1'b0;
      armed_q <= 1'b0;
      sck_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      mr_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      ser_q   <= ser_d;
      armed_q <= armed_d;
      sck_q   <= (state_d == ST_HIGH);
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      mr_n_q  <= (state_d != ST_CLEAR);
    end
  end

  assign READY   = ready_q;
  assign SER     = ser_q;
  assign SCK     = sck_q;
  assign SR_MR_n = mr_n_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_ls164_load_ctrl.sv
// tb/tb_ls164_load_ctrl.sv - directed self-checking bench for ls164_load_ctrl
//
// Three instances: 0 = DIV 2 MSB first, 1 = DIV 2 LSB first, 2 = DIV 1 MSB
// first. Each drives its own 74LS164 model (shift into Q0 on SCK rise,
// async clear on SR_MR_n low) which also counts SCK rises.

module tb_ls164_load_ctrl;

  logic       cp;
  logic       mr;
  logic [7:0] data [3];
  logic [2:0] load;
  logic [2:0] clr;
  logic [2:0] ready;
  logic [2:0] ser;
  logic [2:0] sck;
  logic [2:0] srmr;
  logic [2:0] done;

  int n_assert = 0;
  int n_fail   = 0;

  ls164_load_ctrl #(.DIV(2), .MSB_FIRST(1'b1)) u_a (
    .CP(cp), .MR(mr), .DATA(data[0]), .LOAD(load[0]), .CLR_REQ(clr[0]),
    .READY(ready[0]), .SER(ser[0]), .SCK(sck[0]), .SR_MR_n(srmr[0]), .DONE(done[0])
  );
  ls164_load_ctrl #(.DIV(2), .MSB_FIRST(1'b0)) u_b (
    .CP(cp), .MR(mr), .DATA(data[1]), .LOAD(load[1]), .CLR_REQ(clr[1]),
    .READY(ready[1]), .SER(ser[1]), .SCK(sck[1]), .SR_MR_n(srmr[1]), .DONE(done[1])
  );
  ls164_load_ctrl #(.DIV(1), .MSB_FIRST(1'b1)) u_c (
    .CP(cp), .MR(mr), .DATA(data[2]), .LOAD(load[2]), .CLR_REQ(clr[2]),
    .READY(ready[2]), .SER(ser[2]), .SCK(sck[2]), .SR_MR_n(srmr[2]), .DONE(done[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_model
    logic [7:0] q = 8'h00;
    int         rises = 0;
    always @(posedge sck[g] or negedge srmr[g]) begin
      if (!srmr[g]) begin
        q <= 8'h00;
      end else begin
        q     <= {q[6:0], ser[g]};
        rises <= rises + 1;
      end
    end
  end

  initial cp = 1'b0;
  always #5 cp = ~cp;

  function automatic logic [7:0] model_q(input int u);
    case (u)
      0:       return g_model[0].q;
      1:       return g_model[1].q;
      default: return g_model[2].q;
    endcase
  endfunction

  function automatic int model_rises(input int u);
    case (u)
      0:       return g_model[0].rises;
      1:       return g_model[1].rises;
      default: return g_model[2].rises;
    endcase
  endfunction

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge k; walks edges k+1..k+16*div+1.
  task automatic run_xfer(input int u, input logic [7:0] b, input int div,
                          input bit msb, input bit poke_clr, input logic [7:0] exp_q);
    logic [7:0] bv;
    int         r0;
    int         n;
    bv = b;
    r0 = model_rises(u);
    for (int t = 1; t <= 16 * div; t++) begin
      tick();
      if (poke_clr && t == 3) clr[u] = 1'b1;
      if (poke_clr && t == 4) clr[u] = 1'b0;
      if (t < 16 * div) begin
        chk($sformatf("u%0d t%0d sck", u, t), 32'(sck[u]), 32'((t / div) % 2));
        chk($sformatf("u%0d t%0d done", u, t), 32'(done[u]), 32'd0);
        chk($sformatf("u%0d t%0d ready", u, t), 32'(ready[u]), 32'd0);
        chk($sformatf("u%0d t%0d srmr", u, t), 32'(srmr[u]), 32'd1);
        if (t % (2 * div) == div) begin
          n = (t / div + 1) / 2;
          chk($sformatf("u%0d rise%0d ser", u, n), 32'(ser[u]),
              32'(msb ? bv[8 - n] : bv[n - 1]));
        end
      end else begin
        chk($sformatf("u%0d done pulse", u), 32'(done[u]), 32'd1);
        chk($sformatf("u%0d sck at done", u), 32'(sck[u]), 32'd0);
        chk($sformatf("u%0d ready at done", u), 32'(ready[u]), 32'd0);
        chk($sformatf("u%0d model q", u), 32'(model_q(u)), 32'(exp_q));
        chk($sformatf("u%0d rises", u), 32'(model_rises(u) - r0), 32'd8);
      end
    end
    tick();
    chk($sformatf("u%0d done end", u), 32'(done[u]), 32'd0);
    chk($sformatf("u%0d ready end", u), 32'(ready[u]), 32'd1);
  endtask

  initial begin
    int r_save;
    mr   = 1'b1;
    load = 3'b000;
    clr  = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;

    // Reset values while MR is held.
    tick();
    tick();
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst sck", 32'(sck), 32'd0);
    chk("rst ser", 32'(ser), 32'd0);
    chk("rst srmr", 32'(srmr), 32'd0);
    chk("rst done", 32'(done), 32'd0);

    // Release: CLEAR loads its divider on the first edge, then runs DIV cycles.
    mr = 1'b0;
    tick();
    chk("rel1 srmr", 32'(srmr), 32'd0);
    chk("rel1 ready", 32'(ready), 32'd0);
    tick();
    chk("rel2 srmr", 32'(srmr), 32'b100);
    chk("rel2 ready", 32'(ready), 32'b100);
    tick();
    chk("rel3 srmr", 32'(srmr), 32'b111);
    chk("rel3 ready", 32'(ready), 32'b111);

    // 0xA5 on unit 0; LOAD held and DATA changed to 0x3C while busy,
    // CLR_REQ poked mid-transfer.
    data[0] = 8'hA5;
    load[0] = 1'b1;
    tick();
    chk("a5 accept ready", 32'(ready[0]), 32'd0);
    chk("a5 first ser", 32'(ser[0]), 32'd1);
    chk("a5 accept sck", 32'(sck[0]), 32'd0);
    data[0] = 8'h3C;
    run_xfer(0, 8'hA5, 2, 1'b1, 1'b1, 8'hA5);
    // LOAD still high, so the edge after READY rises accepts 0x3C.
    tick();
    chk("3c accept ready", 32'(ready[0]), 32'd0);
    chk("3c first ser", 32'(ser[0]), 32'd0);
    load[0] = 1'b0;
    run_xfer(0, 8'h3C, 2, 1'b1, 1'b0, 8'h3C);

    // LOAD and CLR_REQ together: clear wins.
    r_save  = model_rises(0);
    data[0] = 8'hFF;
    load[0] = 1'b1;
    clr[0]  = 1'b1;
    tick();
    chk("clr srmr0", 32'(srmr[0]), 32'd0);
    chk("clr ready0", 32'(ready[0]), 32'd0);
    chk("clr sck0", 32'(sck[0]), 32'd0);
    load[0] = 1'b0;
    clr[0]  = 1'b0;
    tick();
    chk("clr srmr1", 32'(srmr[0]), 32'd0);
    chk("clr sck1", 32'(sck[0]), 32'd0);
    chk("clr done1", 32'(done[0]), 32'd0);
    tick();
    chk("clr srmr2", 32'(srmr[0]), 32'd1);
    chk("clr ready2", 32'(ready[0]), 32'd1);
    chk("clr done2", 32'(done[0]), 32'd0);
    chk("clr model q", 32'(model_q(0)), 32'h00);
    chk("clr no rises", 32'(model_rises(0) - r_save), 32'd0);

    // MR after the 3rd SCK rise aborts the transfer.
    r_save  = model_rises(0);
    data[0] = 8'hA5;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("abort pre done", 32'(done[0]), 32'd0);
    end
    chk("abort 3rd rise sck", 32'(sck[0]), 32'd1);
    chk("abort rises", 32'(model_rises(0) - r_save), 32'd3);
    mr = 1'b1;
    #1;
    chk("abort sck", 32'(sck[0]), 32'd0);
    chk("abort ser", 32'(ser[0]), 32'd0);
    chk("abort srmr", 32'(srmr[0]), 32'd0);
    chk("abort ready", 32'(ready[0]), 32'd0);
    chk("abort done", 32'(done[0]), 32'd0);
    tick();
    mr = 1'b0;
    tick();
    chk("abort rel1 srmr", 32'(srmr[0]), 32'd0);
    chk("abort rel1 done", 32'(done[0]), 32'd0);
    tick();
    chk("abort rel2 srmr", 32'(srmr[0]), 32'd0);
    chk("abort rel2 ready", 32'(ready[0]), 32'd0);
    tick();
    chk("abort rel3 srmr", 32'(srmr[0]), 32'd1);
    chk("abort rel3 ready", 32'(ready[0]), 32'd1);
    chk("abort rel3 done", 32'(done[0]), 32'd0);

    // LSB first, 0x01 ends up in Q7.
    data[1] = 8'h01;
    load[1] = 1'b1;
    tick();
    chk("lsb first ser", 32'(ser[1]), 32'd1);
    chk("lsb accept ready", 32'(ready[1]), 32'd0);
    load[1] = 1'b0;
    run_xfer(1, 8'h01, 2, 1'b0, 1'b0, 8'h80);

    // DIV=1: SCK toggles every cycle, DONE at k+16, READY at k+17.
    data[2] = 8'hFF;
    load[2] = 1'b1;
    tick();
    chk("div1 first ser", 32'(ser[2]), 32'd1);
    chk("div1 accept ready", 32'(ready[2]), 32'd0);
    load[2] = 1'b0;
    run_xfer(2, 8'hFF, 1, 1'b1, 1'b0, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ls164_load_ctrl.md
LS164_LOAD_CTRL -- requirements
Module: ls164_load_ctrl

Interface
REQ-001 Parameter DIV, default 2: CP cycles per half-period of the generated shift clock; legal range 1..255.
REQ-002 Parameter MSB_FIRST, default 1: 1 = DATA[7] shifted first (ends in Q7); 0 = DATA[0] shifted first.
REQ-003 One clock, CP; reset is MR, asynchronous and active-high.
REQ-004 CP  input  1  system clock, all state on rising edge.
REQ-005 MR  input  1  asynchronous active-high reset.
REQ-006 DATA  input  8  byte to serialise, sampled on accepted LOAD.
REQ-007 LOAD  input  1  load request (valid); accepted when LOAD & READY at a CP rising edge.
REQ-008 CLR_REQ  input  1  request to clear the downstream 74LS164.
REQ-009 READY  output  1  controller idle, able to accept LOAD or CLR_REQ.
REQ-010 SER  output  1  serial data, drives DSA and DSB of the downstream register.
REQ-011 SCK  output  1  generated shift clock, drives CP of the downstream register.
REQ-012 SR_MR_n  output  1  active-low clear to downstream MR_n.
REQ-013 DONE  output  1  one-CP-cycle pulse after the 8th shift completes.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 States SHALL be CLEAR, IDLE, SETUP, HIGH, DONE.
REQ-016 IDLE: READY=1, SCK=0, SR_MR_n=1, DONE=0, SER holds last value.
REQ-017 IDLE + CLR_REQ -> CLEAR; IDLE + LOAD (no CLR_REQ) -> SETUP; CLR_REQ has priority when both asserted.
REQ-018 On LOAD acceptance at edge k: DATA captured into internal byte register, bit counter=0, SER = first bit from edge k.
REQ-019 SETUP: SCK=0 for DIV cycles with SER stable; then -> HIGH.
REQ-020 HIGH: SCK=1 for DIV cycles (rising SCK edge at entry, SER unchanged during HIGH); at exit bit counter increments.
REQ-021 HIGH exit with counter <7 -> SETUP with SER updated to next bit at the same edge SCK falls; counter =7 -> DONE.
REQ-022 Timing: nth SCK rise (n=1..8) at edge k+(2n-1)*DIV; DONE=1 for cycle starting edge k+16*DIV; READY=1 from edge k+16*DIV+1.
REQ-023 DONE state: SCK=0, DONE=1 for exactly one cycle, then -> IDLE.
REQ-024 CLEAR: SR_MR_n=0, SCK=0, READY=0 for DIV cycles, then -> IDLE with SR_MR_n=1; DONE not asserted for clears.
REQ-025 LOAD and CLR_REQ while READY=0 SHALL be ignored (no queuing); DATA changes during a transfer SHALL NOT affect SER.
REQ-026 Divider counter SHALL be 8 bits and reload to DIV-1 on each state entry; DIV=1 yields SCK period of 2 CP cycles.
REQ-027 Bit counter SHALL be 3 bits plus terminal detect; no wrap beyond 8 shifts per LOAD.

Reset
REQ-028 MR=1 SHALL immediately force: state CLEAR, SCK=0, SER=0, SR_MR_n=0, READY=0, DONE=0, counters 0.
REQ-029 After MR falls, CLEAR SHALL run its full DIV cycles before IDLE, guaranteeing a downstream clear after every reset.
REQ-030 MR asserted mid-transfer SHALL abort it with no DONE pulse; SCK SHALL not glitch high.

Verification
REQ-031 DIV=2, MSB_FIRST=1, LOAD DATA=0xA5 at edge k -> SER bits 1,0,1,0,0,1,0,1 at SCK rises k+2,k+6,...,k+30; DONE at k+32; 74LS164 model Q7..Q0=0xA5.
REQ-032 MSB_FIRST=0, DATA=0x01 -> first SER bit 1, rest 0; model Q7..Q0=0x80 after DONE.
REQ-033 DIV=1, DATA=0xFF -> SCK toggles every cycle, 8 rises, DONE at k+16, READY at k+17.
REQ-034 LOAD and CLR_REQ same edge in IDLE -> SR_MR_n=0 for DIV cycles, no SCK edges, no DONE, model Q=0x00.
REQ-035 MR pulsed after 3rd SCK rise -> outputs reset values immediately, no DONE, SR_MR_n low until DIV cycles after MR release, then READY=1.
REQ-036 LOAD held high with new DATA=0x3C during busy -> ignored; transfer completes with original byte, next LOAD accepted only when READY=1.
